// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared FSM encodings, requester indices, mem_func codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int         c_ST_W        = 2;
    localparam logic [1:0] c_ARB_IDLE    = 2'd0;
    localparam logic [1:0] c_ARB_ISSUE   = 2'd1;
    localparam logic [1:0] c_ARB_WAIT    = 2'd2;
    localparam logic [1:0] c_ARB_DONE    = 2'd3;

    localparam int c_REQ_TRAVERSAL = 0;
    localparam int c_REQ_EXECUTE   = 1;
    localparam int c_REQ_OPER      = 2;

    // Code 0 is the idle/no-op function driven whenever no op is being issued
    localparam logic [1:0] c_MEM_NOP          = 2'b00;
    localparam logic [1:0] c_MEM_GET_CONTENTS = 2'b01;
    localparam logic [1:0] c_MEM_SET_CONTENTS = 2'b10;
    localparam logic [1:0] c_MEM_GET_PAIR     = 2'b11;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_priority_pick.sv
// ============================================================================
// mem_port_arbiter_rr_priority_pick : circular first-one finder starting at i_ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter_rr_priority_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && i_req[wrap_add(int'(i_ptr), k, NUM_REQ)]) begin
                o_any = 1'b1;
                o_grant[wrap_add(int'(i_ptr), k, NUM_REQ)] = 1'b1;
                o_idx = IDX_W'(wrap_add(int'(i_ptr), k, NUM_REQ));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin owner of the single memory_unit port, with
//                    locked multi-op sequences and a stuck-memory watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [2*NUM_REQ-1:0]      req_func,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr1,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr2,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         rdata1,
    output logic [DATA_W-1:0]         rdata2,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      mem_execute,
    output logic [1:0]                mem_func,
    output logic [ADDR_W-1:0]         address1,
    output logic [ADDR_W-1:0]         address2,
    output logic [DATA_W-1:0]         write_data,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         read_data1,
    input  logic [DATA_W-1:0]         read_data2,
    output logic                      timeout_err
);

    localparam int c_IDX_W = idx_width(NUM_REQ);
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [c_IDX_W-1:0] r_owner;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic               r_locked;
    logic               r_aborted;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mem_execute;
    logic [1:0]         r_mem_func;
    logic [ADDR_W-1:0]  r_address1;
    logic [ADDR_W-1:0]  r_address2;
    logic [DATA_W-1:0]  r_write_data;
    logic [DATA_W-1:0]  r_rdata1;
    logic [DATA_W-1:0]  r_rdata2;
    logic               r_timeout_err;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [c_IDX_W-1:0] w_pick_idx;
    logic               w_pick_any;
    logic               w_start;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic               w_tmo;
    logic [NUM_REQ-1:0] w_req_done;

    mem_port_arbiter_rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // A held lock bypasses arbitration: only the current owner may re-enter
    assign w_start   = r_locked ? req_valid[r_owner] : w_pick_any;
    assign w_sel_idx = r_locked ? r_owner : w_pick_idx;
    assign w_tmo     = (TIMEOUT != 0) && (r_cnt == c_TMO_LAST) && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ARB_IDLE:  if (w_start) w_state_nxt = c_ARB_ISSUE;
            c_ARB_ISSUE: w_state_nxt = c_ARB_WAIT;
            c_ARB_WAIT:  if (mem_ready || w_tmo) w_state_nxt = c_ARB_DONE;
            c_ARB_DONE:  w_state_nxt = c_ARB_IDLE;
            default:     w_state_nxt = c_ARB_IDLE;
        endcase
    end

    always_comb begin
        w_req_done = '0;
        if (r_state == c_ARB_DONE) begin
            w_req_done = r_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant       <= '0;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_locked      <= 1'b0;
            r_aborted     <= 1'b0;
            r_cnt         <= '0;
            r_mem_execute <= 1'b0;
            r_mem_func    <= c_MEM_NOP;
            r_address1    <= '0;
            r_address2    <= '0;
            r_write_data  <= '0;
            r_rdata1      <= '0;
            r_rdata2      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mem_execute <= (r_state == c_ARB_ISSUE);
            case (r_state)
                c_ARB_IDLE: begin
                    if (w_start) begin
                        if (!r_locked) begin
                            r_grant <= w_pick_grant;
                            r_owner <= w_pick_idx;
                        end
                        r_mem_func   <= req_func[w_sel_idx*2 +: 2];
                        r_address1   <= req_addr1[w_sel_idx*ADDR_W +: ADDR_W];
                        r_address2   <= req_addr2[w_sel_idx*ADDR_W +: ADDR_W];
                        r_write_data <= req_wdata[w_sel_idx*DATA_W +: DATA_W];
                    end
                end
                c_ARB_ISSUE: begin
                    r_cnt     <= '0;
                    r_aborted <= 1'b0;
                end
                c_ARB_WAIT: begin
                    r_mem_func <= c_MEM_NOP;
                    if (mem_ready) begin
                        r_rdata1 <= read_data1;
                        r_rdata2 <= read_data2;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (w_tmo) begin
                            r_timeout_err <= 1'b1;
                            r_aborted     <= 1'b1;
                        end
                    end
                end
                c_ARB_DONE: begin
                    // An aborted op never keeps the port, so a stuck owner cannot starve others
                    if (req_lock[r_owner] && !r_aborted) begin
                        r_locked <= 1'b1;
                    end else begin
                        r_locked <= 1'b0;
                        r_grant  <= '0;
                        r_rr_ptr <= (r_owner == c_LAST_IDX) ? '0 : r_owner + c_IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_done    = w_req_done;
    assign grant       = r_grant;
    assign mem_execute = r_mem_execute;
    assign mem_func    = r_mem_func;
    assign address1    = r_address1;
    assign address2    = r_address2;
    assign write_data  = r_write_data;
    assign rdata1      = r_rdata1;
    assign rdata2      = r_rdata2;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed vector table plus hand sequences for lock,
//                       timeout, reset and stray-handshake corner cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [7:0]  req_func;
    logic [31:0] req_addr1;
    logic [31:0] req_addr2;
    logic [31:0] req_wdata;
    logic [3:0]  req_done;
    logic [7:0]  rdata1;
    logic [7:0]  rdata2;
    logic [3:0]  grant;
    logic        mem_execute;
    logic [1:0]  mem_func;
    logic [7:0]  address1;
    logic [7:0]  address2;
    logic [7:0]  write_data;
    logic        mem_ready;
    logic [7:0]  read_data1;
    logic [7:0]  read_data2;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] last_rd;

    typedef struct {
        logic [3:0] add_valid;
        logic [3:0] lock;
        logic [7:0] func;
        int         exp_owner;
        int         ready_dly;
        logic [7:0] rd1;
    } vec_t;

    vec_t vecs[10];

    mem_port_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_func    (req_func),
        .req_addr1   (req_addr1),
        .req_addr2   (req_addr2),
        .req_wdata   (req_wdata),
        .req_done    (req_done),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .grant       (grant),
        .mem_execute (mem_execute),
        .mem_func    (mem_func),
        .address1    (address1),
        .address2    (address2),
        .write_data  (write_data),
        .mem_ready   (mem_ready),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction
    function automatic logic [7:0] a1(input int i);
        return 8'(5 + 16 * i);
    endfunction
    function automatic logic [7:0] a2(input int i);
        return 8'(8'h40 + i);
    endfunction
    function automatic logic [7:0] wd(input int i);
        return 8'(8'hA0 + i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_exec(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_execute && n < 20);
    endtask

    task automatic run_vec(input vec_t v);
        int         n;
        logic [1:0] f;
        logic [7:0] rd2;
        rd2       = ~v.rd1;
        req_valid = req_valid | v.add_valid;
        req_lock  = v.lock;
        req_func  = v.func;
        f         = v.func[2*v.exp_owner +: 2];
        wait_exec(n);
        chk("exec_latency", n, 2);
        chk("grant", grant, oh(v.exp_owner));
        chk("address1", address1, a1(v.exp_owner));
        chk("address2", address2, a2(v.exp_owner));
        chk("write_data", write_data, wd(v.exp_owner));
        chk("mem_func", mem_func, f);
        if (v.ready_dly > 0) begin
            @(negedge clk);
            chk("exec_pulse", mem_execute, 0);
            chk("func_cleared", mem_func, 0);
            repeat (v.ready_dly - 1) @(negedge clk);
        end
        mem_ready  = 1'b1;
        read_data1 = v.rd1;
        read_data2 = rd2;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("req_done", req_done, oh(v.exp_owner));
        chk("rdata1", rdata1, v.rd1);
        chk("rdata2", rdata2, rd2);
        last_rd = v.rd1;
        @(negedge clk);
        chk("done_one_cycle", req_done, 0);
        req_valid[v.exp_owner] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic bad;
        logic early;

        vecs[0] = '{4'b1111, 4'b0000, 8'h55, 0, 3, 8'hAB};
        vecs[1] = '{4'b0001, 4'b0000, 8'h55, 1, 1, 8'h11};
        vecs[2] = '{4'b0010, 4'b0000, 8'h55, 2, 0, 8'h22};
        vecs[3] = '{4'b0100, 4'b0000, 8'h55, 3, 2, 8'h33};
        vecs[4] = '{4'b1000, 4'b0000, 8'h55, 0, 1, 8'h44};
        vecs[5] = '{4'b0000, 4'b0000, 8'h55, 1, 1, 8'h55};
        vecs[6] = '{4'b0001, 4'b0100, 8'h55, 2, 2, 8'h66};
        vecs[7] = '{4'b0100, 4'b0000, 8'h65, 2, 1, 8'h77};
        vecs[8] = '{4'b0000, 4'b0000, 8'h55, 3, 0, 8'h88};
        vecs[9] = '{4'b0000, 4'b0000, 8'h55, 0, 2, 8'h99};

        rst        = 1'b1;
        req_valid  = '0;
        req_lock   = '0;
        req_func   = 8'h55;
        mem_ready  = 1'b0;
        read_data1 = '0;
        read_data2 = '0;
        last_rd    = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr1[i*8 +: 8] = a1(i);
            req_addr2[i*8 +: 8] = a2(i);
            req_wdata[i*8 +: 8] = wd(i);
        end

        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_req_done", req_done, 0);
        chk("rst_mem_execute", mem_execute, 0);
        chk("rst_address1", address1, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Contention order, locked read-modify-write, then drain
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Requester drops req_valid right after issue; then stray mem_ready in IDLE
        req_func     = 8'h65;
        req_valid[2] = 1'b1;
        wait_exec(n);
        chk("drop_latency", n, 2);
        chk("drop_grant", grant, 4'b0100);
        chk("drop_func", mem_func, 2'b10);
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("drop_func_cleared", mem_func, 0);
        mem_ready  = 1'b1;
        read_data1 = 8'h5A;
        read_data2 = 8'hA5;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("drop_req_done", req_done, 4'b0100);
        chk("drop_rdata1", rdata1, 8'h5A);
        last_rd = 8'h5A;
        @(negedge clk);
        chk("drop_grant_released", grant, 0);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_execute || req_done != 0) bad = 1'b1;
        end
        chk("drop_no_reissue", bad, 0);
        mem_ready  = 1'b1;
        read_data1 = 8'hEE;
        bad        = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_execute || req_done != 0) bad = 1'b1;
        end
        mem_ready = 1'b0;
        chk("stray_ready_ignored", bad, 0);
        chk("stray_rdata_held", rdata1, last_rd);

        // Watchdog abort on a locked owner; the lock must be released
        req_func  = 8'h55;
        req_lock  = 4'b1000;
        req_valid = 4'b1000;
        wait_exec(n);
        chk("tmo_latency", n, 2);
        chk("tmo_grant", grant, 4'b1000);
        req_valid[1] = 1'b1;
        n     = 0;
        early = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (req_done == 0 && timeout_err) early = 1'b1;
        end while (req_done == 0 && n < 20);
        chk("tmo_cycles", n, 8);
        chk("tmo_early_err", early, 0);
        chk("tmo_err_set", timeout_err, 1);
        chk("tmo_req_done", req_done, 4'b1000);
        chk("tmo_rdata_held", rdata1, last_rd);
        @(negedge clk);
        chk("tmo_done_one_cycle", req_done, 0);
        run_vec('{4'b0000, 4'b1000, 8'h55, 1, 1, 8'hC1});
        run_vec('{4'b0000, 4'b0000, 8'h55, 3, 1, 8'hC3});
        chk("tmo_err_sticky", timeout_err, 1);

        // Asynchronous reset in the middle of WAIT
        req_valid = 4'b0001;
        wait_exec(n);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_req_done", req_done, 0);
        chk("mid_rst_mem_execute", mem_execute, 0);
        chk("mid_rst_mem_func", mem_func, 0);
        chk("mid_rst_address1", address1, 0);
        chk("mid_rst_address2", address2, 0);
        chk("mid_rst_write_data", write_data, 0);
        chk("mid_rst_rdata1", rdata1, 0);
        chk("mid_rst_rdata2", rdata2, 0);
        chk("mid_rst_timeout_err", timeout_err, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (mem_execute || req_done != 0) bad = 1'b1;
        end
        chk("post_rst_quiet", bad, 0);
        run_vec('{4'b0011, 4'b0000, 8'h55, 0, 2, 8'hD0});
        run_vec('{4'b0000, 4'b0000, 8'h55, 1, 0, 8'hD1});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
